// File: rtl/wb_grf_pkg.sv
// Shared encodings for the write-back stage: MIPS opcode/funct values,
// the link register index, and the write-back source and load-kind types.
package wb_grf_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_DM, WB_PC8} wb_src_e;
  typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_kind_e;

  // R-type functs whose result comes straight from the ALU.
  function automatic logic is_alu_funct(logic [5:0] fn);
    case (fn)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_NOR, FN_XOR,
      FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_grf_decode.sv
// Combinational instruction decoder: destination register, write-back source
// and load kind. Kept standalone so the hazard unit can reuse it.
module wb_decode
  import wb_grf_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  dest_o,
  output wb_src_e     wb_src_o,
  output ld_kind_e    ld_kind_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_fields;

  assign op = instr_i[31:26];
  assign fn = instr_i[5:0];
  assign rt = instr_i[20:16];
  assign rd = instr_i[15:11];
  assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

  always_comb begin
    dest_o    = '0;
    wb_src_o  = WB_NONE;
    ld_kind_o = LD_W;
    case (op)
      OP_RTYPE: begin
        if (is_alu_funct(fn)) begin
          dest_o   = rd;
          wb_src_o = WB_ALU;
        end else if (fn == FN_JALR) begin
          dest_o   = rd;
          wb_src_o = WB_PC8;
        end
      end
      OP_JAL: begin
        dest_o   = REG_RA;
        wb_src_o = WB_PC8;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU: begin
        dest_o   = rt;
        wb_src_o = WB_ALU;
      end
      OP_LW:  begin dest_o = rt; wb_src_o = WB_DM; ld_kind_o = LD_W;  end
      OP_LB:  begin dest_o = rt; wb_src_o = WB_DM; ld_kind_o = LD_B;  end
      OP_LBU: begin dest_o = rt; wb_src_o = WB_DM; ld_kind_o = LD_BU; end
      OP_LH:  begin dest_o = rt; wb_src_o = WB_DM; ld_kind_o = LD_H;  end
      OP_LHU: begin dest_o = rt; wb_src_o = WB_DM; ld_kind_o = LD_HU; end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Write-back stage and 32x32 general register file with W->D read bypass,
// exported write-back triple for forwarding, and a retired-instruction counter.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int INSTRET_W = 32,
  parameter int BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 w_flag,
  input  logic [31:0]          w_pc,
  input  logic [31:0]          w_instr,
  input  logic [DATA_W-1:0]    w_alu_out,
  input  logic [DATA_W-1:0]    w_dm_out,
  input  logic [4:0]           rs_addr_D,
  input  logic [4:0]           rt_addr_D,
  output logic [DATA_W-1:0]    rs_data_D,
  output logic [DATA_W-1:0]    rt_data_D,
  output logic                 wb_en,
  output logic [4:0]           wb_addr,
  output logic [DATA_W-1:0]    wb_data,
  output logic [INSTRET_W-1:0] instret
);

  localparam bit BypassOn = (BYPASS != 0);

  logic [4:0]           dest;
  wb_src_e              wb_src;
  ld_kind_e             ld_kind;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [DATA_W-1:0]    ld_data;
  logic [DATA_W-1:0]    sel_data;
  logic [DATA_W-1:0]    grf_q [32];
  logic [INSTRET_W-1:0] instret_q;
  logic [INSTRET_W-1:0] instret_d;

  wb_decode u_decode (
    .instr_i   (w_instr),
    .dest_o    (dest),
    .wb_src_o  (wb_src),
    .ld_kind_o (ld_kind)
  );

  assign ld_byte = w_dm_out[{w_alu_out[1:0], 3'b000} +: 8];
  assign ld_half = w_alu_out[1] ? w_dm_out[31:16] : w_dm_out[15:0];

  always_comb begin
    ld_data = w_dm_out;
    case (ld_kind)
      LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   ld_data = {24'd0, ld_byte};
      LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      LD_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = w_dm_out;
    endcase
  end

  always_comb begin
    sel_data = '0;
    case (wb_src)
      WB_ALU:  sel_data = w_alu_out;
      WB_DM:   sel_data = ld_data;
      WB_PC8:  sel_data = w_pc + 32'd8;
      default: sel_data = '0;
    endcase
  end

  // A disabled write exports zeros so forwarding comparators can never match.
  assign wb_en   = w_flag && (wb_src != WB_NONE) && (dest != 5'd0);
  assign wb_addr = wb_en ? dest : 5'd0;
  assign wb_data = wb_en ? sel_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) grf_q[i] <= '0;
    end else if (wb_en) begin
      grf_q[wb_addr] <= wb_data;
    end
  end

  assign instret_d = instret_q + INSTRET_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instret_q <= '0;
    else if (w_flag) instret_q <= instret_d;
  end

  assign instret = instret_q;

  always_comb begin
    if (rs_addr_D == 5'd0)                                 rs_data_D = '0;
    else if (BypassOn && wb_en && (rs_addr_D == wb_addr))  rs_data_D = wb_data;
    else                                                   rs_data_D = grf_q[rs_addr_D];
  end

  always_comb begin
    if (rt_addr_D == 5'd0)                                 rt_data_D = '0;
    else if (BypassOn && wb_en && (rt_addr_D == wb_addr))  rt_data_D = wb_data;
    else                                                   rt_data_D = grf_q[rt_addr_D];
  end

endmodule

// File: tb/tb_wb_grf.sv
// Testbench for wb_grf: a bypassing 32-bit-counter instance and a raw-read
// 4-bit-counter instance share stimulus and are checked against a register-file model.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic        wFlag;
  logic [31:0] wPc, wInstr, wAlu, wDm;
  logic [4:0]  rsAddr, rtAddr;

  logic [31:0] aRs, aRt, aData, aCnt;
  logic        aEn;
  logic [4:0]  aAddr;
  logic [31:0] bRs, bRt, bData;
  logic [3:0]  bCnt;
  logic        bEn;
  logic [4:0]  bAddr;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] mReg [32];
  logic [31:0] mCnt;

  always #5 clk = ~clk;

  wb_grf #(.DATA_W(32), .INSTRET_W(32), .BYPASS(1)) dutA (
    .clk(clk), .reset(reset), .w_flag(wFlag), .w_pc(wPc), .w_instr(wInstr),
    .w_alu_out(wAlu), .w_dm_out(wDm), .rs_addr_D(rsAddr), .rt_addr_D(rtAddr),
    .rs_data_D(aRs), .rt_data_D(aRt), .wb_en(aEn), .wb_addr(aAddr),
    .wb_data(aData), .instret(aCnt)
  );

  wb_grf #(.DATA_W(32), .INSTRET_W(4), .BYPASS(0)) dutB (
    .clk(clk), .reset(reset), .w_flag(wFlag), .w_pc(wPc), .w_instr(wInstr),
    .w_alu_out(wAlu), .w_dm_out(wDm), .rs_addr_D(rsAddr), .rt_addr_D(rtAddr),
    .rs_data_D(bRs), .rt_data_D(bRt), .wb_en(bEn), .wb_addr(bAddr),
    .wb_data(bData), .instret(bCnt)
  );

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference write-back computed directly from the MIPS instruction semantics.
  function automatic void modelWb(input logic flag, input logic [31:0] pc, input logic [31:0] instr,
                                  input logic [31:0] alu, input logic [31:0] dm,
                                  output logic en, output logic [4:0] addr, output logic [31:0] data);
    int          op = int'(instr[31:26]);
    int          fn = int'(instr[5:0]);
    int          dest = 0;
    logic [31:0] val = 32'd0;
    logic [7:0]  b = 8'(dm >> (8 * int'(alu[1:0])));
    logic [15:0] h = alu[1] ? dm[31:16] : dm[15:0];
    if (op == 0 && fn inside {32, 33, 34, 35, 36, 37, 39, 38, 42, 43, 0, 2, 3}) begin
      dest = int'(instr[15:11]); val = alu;
    end else if (op == 0 && fn == 9) begin
      dest = int'(instr[15:11]); val = pc + 32'd8;
    end else if (op inside {8, 9, 12, 13, 14, 15, 10, 11}) begin
      dest = int'(instr[20:16]); val = alu;
    end else if (op == 3) begin
      dest = 31; val = pc + 32'd8;
    end else if (op == 35) begin
      dest = int'(instr[20:16]); val = dm;
    end else if (op == 32) begin
      dest = int'(instr[20:16]); val = {{24{b[7]}}, b};
    end else if (op == 36) begin
      dest = int'(instr[20:16]); val = {24'd0, b};
    end else if (op == 33) begin
      dest = int'(instr[20:16]); val = {{16{h[15]}}, h};
    end else if (op == 37) begin
      dest = int'(instr[20:16]); val = {16'd0, h};
    end
    en   = flag && (dest != 0);
    addr = en ? 5'(dest) : 5'd0;
    data = en ? val : 32'd0;
  endfunction

  function automatic logic [31:0] expRead(logic [4:0] ra, logic bypass, logic en, logic [4:0] wa, logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
    if (bypass && en && ra == wa) return wd;
    return mReg[ra];
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mReg[i] = 32'd0;
    mCnt = 32'd0;
  endtask

  // Drive one W-stage cycle, check combinational outputs mid-cycle, clock it, check counters.
  task automatic applyStimulus(logic flag, logic [31:0] pc, logic [31:0] instr, logic [31:0] alu,
                               logic [31:0] dm, logic [4:0] rsA, logic [4:0] rtA);
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    wFlag = flag; wPc = pc; wInstr = instr; wAlu = alu; wDm = dm; rsAddr = rsA; rtAddr = rtA;
    #2;
    modelWb(flag, pc, instr, alu, dm, en, addr, data);
    checkOutput("wb_en",   {31'd0, aEn},   {31'd0, en});
    checkOutput("wb_addr", {27'd0, aAddr}, {27'd0, addr});
    checkOutput("wb_data", aData, data);
    checkOutput("wb_data_nobyp", bData, data);
    checkOutput("rs_byp", aRs, expRead(rsA, 1'b1, en, addr, data));
    checkOutput("rt_byp", aRt, expRead(rtA, 1'b1, en, addr, data));
    checkOutput("rs_raw", bRs, expRead(rsA, 1'b0, en, addr, data));
    checkOutput("rt_raw", bRt, expRead(rtA, 1'b0, en, addr, data));
    @(posedge clk);
    #1;
    if (en) mReg[addr] = data;
    if (flag) mCnt = mCnt + 32'd1;
    checkOutput("instret",  aCnt, mCnt);
    checkOutput("instret4", {28'd0, bCnt}, {28'd0, mCnt[3:0]});
  endtask

  task automatic readReg(logic [4:0] ra, logic [31:0] exp, string tag);
    wFlag = 1'b0; rsAddr = ra; rtAddr = ra;
    #2;
    checkOutput(tag, aRs, exp);
    checkOutput(tag, bRt, exp);
  endtask

  function automatic logic [31:0] randInstr();
    int ops [19] = '{0, 3, 8, 9, 12, 13, 14, 15, 10, 11, 35, 32, 36, 33, 37, 43, 4, 2, 63};
    int fns [17] = '{32, 33, 34, 35, 36, 37, 39, 38, 42, 43, 0, 2, 3, 9, 8, 24, 26};
    logic [31:0] r = $urandom;
    int op = ops[$urandom_range(0, 18)];
    if (op == 0) return {6'd0, r[25:6], 6'(fns[$urandom_range(0, 16)])};
    return {6'(op), r[25:0]};
  endfunction

  localparam logic [31:0] JAL  = {6'h03, 26'd0};
  localparam logic [31:0] DMW  = 32'h80FF7F01;

  initial begin
    logic [31:0] ri;
    reset = 1'b0; wFlag = 1'b1; wPc = 32'h3000; wInstr = JAL; wAlu = 32'd0; wDm = 32'd0;
    rsAddr = 5'd0; rtAddr = 5'd0;
    modelReset();

    // Held in reset with a valid jal: nothing is written or counted.
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_instret", aCnt, 32'd0);
    checkOutput("rst_instret4", {28'd0, bCnt}, 32'd0);
    readReg(5'd31, 32'd0, "rst_r31");
    #2 reset = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h3000, JAL, 32'd0, 32'd0, 5'd31, 5'd0);
    readReg(5'd31, 32'h3008, "jal_r31");
    checkOutput("jal_instret", aCnt, 32'd3);

    // Asynchronous reset between edges clears the array immediately.
    reset = 1'b0;
    #1;
    checkOutput("async_r31", aRs, 32'd0);
    checkOutput("async_instret", aCnt, 32'd0);
    modelReset();
    #1 reset = 1'b1;

    applyStimulus(1'b1, 32'h3004, itype(6'h0d, 5'd0, 5'd5, 16'h1234), 32'h1234, 32'd0, 5'd5, 5'd0);
    readReg(5'd5, 32'h1234, "ori_r5");
    applyStimulus(1'b1, 32'h3008, rtype(5'd1, 5'd2, 5'd0, 6'h21), 32'hFFFF, 32'd0, 5'd0, 5'd0);
    checkOutput("addu0_instret", aCnt, 32'd2);

    applyStimulus(1'b1, 32'h3010, itype(6'h20, 5'd0, 5'd8, 16'd3), 32'h1003, DMW, 5'd0, 5'd0);
    readReg(5'd8, 32'hFFFFFF80, "lb_off3");
    applyStimulus(1'b1, 32'h3014, itype(6'h24, 5'd0, 5'd8, 16'd3), 32'h1003, DMW, 5'd0, 5'd0);
    readReg(5'd8, 32'h00000080, "lbu_off3");
    applyStimulus(1'b1, 32'h3018, itype(6'h20, 5'd0, 5'd8, 16'd0), 32'h1000, DMW, 5'd0, 5'd0);
    readReg(5'd8, 32'h00000001, "lb_off0");
    applyStimulus(1'b1, 32'h301c, itype(6'h21, 5'd0, 5'd8, 16'd2), 32'h1002, DMW, 5'd0, 5'd0);
    readReg(5'd8, 32'hFFFF80FF, "lh_off2");
    applyStimulus(1'b1, 32'h3020, itype(6'h25, 5'd0, 5'd8, 16'd2), 32'h1002, DMW, 5'd0, 5'd0);
    readReg(5'd8, 32'h000080FF, "lhu_off2");
    applyStimulus(1'b1, 32'h3024, itype(6'h23, 5'd0, 5'd8, 16'd0), 32'h1000, DMW, 5'd0, 5'd0);
    readReg(5'd8, 32'h80FF7F01, "lw");

    // Same-cycle bypass on both ports versus raw array read.
    applyStimulus(1'b1, 32'h3028, itype(6'h0d, 5'd0, 5'd9, 16'h11), 32'h11, 32'd0, 5'd0, 5'd0);
    wFlag = 1'b1; wInstr = itype(6'h0d, 5'd0, 5'd9, 16'h22); wAlu = 32'h22; rsAddr = 5'd9; rtAddr = 5'd9;
    #2;
    checkOutput("byp_rs", aRs, 32'h22);
    checkOutput("byp_rt", aRt, 32'h22);
    checkOutput("nobyp_rs", bRs, 32'h11);
    applyStimulus(1'b1, 32'h302c, itype(6'h0d, 5'd0, 5'd9, 16'h22), 32'h22, 32'd0, 5'd9, 5'd9);
    readReg(5'd9, 32'h22, "byp_next");

    // Bubble, then valid ops that never write.
    applyStimulus(1'b0, 32'h3030, itype(6'h0d, 5'd0, 5'd4, 16'h55), 32'h55, 32'd0, 5'd4, 5'd0);
    checkOutput("bubble_addr", {27'd0, aAddr}, 32'd0);
    readReg(5'd4, 32'd0, "bubble_r4");
    applyStimulus(1'b1, 32'h3034, itype(6'h04, 5'd1, 5'd2, 16'h4), 32'h0, 32'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 32'h3038, itype(6'h2b, 5'd1, 5'd2, 16'h4), 32'h1004, 32'd7, 5'd2, 5'd0);
    applyStimulus(1'b1, 32'h303c, rtype(5'd31, 5'd0, 5'd0, 6'h08), 32'h0, 32'd0, 5'd31, 5'd0);
    applyStimulus(1'b1, 32'h3010, rtype(5'd3, 5'd0, 5'd7, 6'h09), 32'h0, 32'd0, 5'd0, 5'd0);
    readReg(5'd7, 32'h3018, "jalr_r7");

    for (int i = 0; i < 200; i++) begin
      ri = randInstr();
      applyStimulus(($urandom_range(0, 7) != 0), $urandom, ri, $urandom, $urandom,
                    5'($urandom_range(0, 31)), ri[20:16]);
    end

    // Counter wrap on the 4-bit instance.
    reset = 1'b0;
    #1 modelReset();
    #1 reset = 1'b1;
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 32'h3000, JAL, 32'd0, 32'd0, 5'd0, 5'd0);
    checkOutput("wrap_instret4", {28'd0, bCnt}, 32'd1);
    checkOutput("wrap_instret32", aCnt, 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Write-back stage plus general register file for the 5-stage MIPS pipeline.
- Consumes the W-stage bundle: valid flag, pc, instr, alu_out, dm_out.
- Decodes the destination register and write-back source, extracts load bytes/halves, and writes the 32x32 GRF.
- Serves the two D-stage read ports with same-cycle W->D bypass, exports the write-back triple for forwarding, and counts retired instructions.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- INSTRET_W, 32, retired-instruction counter width.
- BYPASS, 1, 1 enables the internal W->D read bypass; 0 gives raw array reads.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset asserted); clears the GRF and counter
- w_flag  in  1  W-stage valid; 0 = bubble, which produces no write and no count
- w_pc  in  32  W-stage pc
- w_instr  in  32  W-stage instruction
- w_alu_out  in  32  ALU result, also the memory address for loads
- w_dm_out  in  32  aligned data-memory word read
- rs_addr_D  in  5  read port 1 address
- rt_addr_D  in  5  read port 2 address
- rs_data_D  out  32  read port 1 data, combinational
- rt_data_D  out  32  read port 2 data, combinational
- wb_en  out  1  write happens at the next edge; combinational
- wb_addr  out  5  destination register; combinational
- wb_data  out  32  write data; combinational
- instret  out  INSTRET_W  count of retired valid instructions

Behaviour:
- Reset is asynchronous:
  - While reset=0, all 32 registers and instret are 0, and this is visible immediately.
  - The GRF and counter hold 0 through any clock edge while reset is 0.
  - A reset in the middle of a write discards that write.
- Destination and source decode (op = instr[31:26], fn = instr[5:0]):
  - R-type, op=0, fn in {add, addu, sub, subu, and, or, nor, xor, slt, sltu, sll, srl, sra}: dest rd, data alu_out.
  - R-type jalr, op=0, fn=001001: dest rd, data pc+8.
  - I-type op in {addi 001000, addiu 001001, andi 001100, ori 001101, xori 001110, lui 001111, slti 001010, sltiu 001011}: dest rt, data alu_out.
  - jal, op=000011: dest 31, data pc+8.
  - Every other encoding (branches, j, jr, stores, mult/div class, unknown) produces no write.
- Load extraction (byte offset = alu_out[1:0], little-endian, dest rt):
  - lw (100011): dm_out.
  - lb (100000) sign-extends the selected byte; lbu (100100) zero-extends it.
  - lh (100001) sign-extends the half selected by alu_out[1]; lhu (100101) zero-extends it.
  - alu_out[0] is ignored for halves; misalignment trapping is the M stage's job.
- wb_en = w_flag & decoded_write & (dest != 0).
  - wb_addr = dest; wb_data = the selected data.
  - When wb_en=0, wb_addr and wb_data are forced to 0 so that forwarding comparators never match.
- Write: at posedge, when wb_en=1, GRF[wb_addr] <= wb_data. Register 0 always reads 0 and is never written.
- Read ports:
  - A read of address 0 returns 0.
  - With BYPASS=1 and wb_en=1, a read whose address equals wb_addr returns wb_data in the same cycle.
  - Otherwise a read returns the array value.
  - Both ports may read the same address or hit the bypass simultaneously.
- instret:
  - Increments by 1 at each posedge where w_flag=1, whether or not a write occurs; nop (all-zero instr) counts.
  - Wraps from 2^INSTRET_W-1 to 0 with no flag.
- Latency: a write-back value is visible on D reads in the same cycle (bypass) and from the array one cycle later.

Decomposition:
- A shared package holds:
  - opcode/funct localparams (OP_RTYPE, OP_JAL, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_ORI, OP_LUI, ..., FN_JALR, FN_ADDU, ...);
  - the REG_RA = 31 constant;
  - a wb_src enum {WB_NONE, WB_ALU, WB_DM, WB_PC8}.
- One sub-module, wb_decode, is natural: a purely combinational instr -> {dest, wb_src, load kind} decoder, reusable by the hazard unit.
- Load extraction, write mux, array, bypass and counter stay in wb_grf.

Test Plan:
- Reset/counter: hold reset=0 with w_flag=1 and jal pc=0x3000 -> no write, instret=0. Release reset, then run 3 valid cycles with jal pc=0x3000 -> GRF[31]=0x3008 and instret=3. Assert reset=0 between edges -> rs_data_D(31)=0 immediately.
- R/I/$0: ori rt=5, alu_out=0x1234 -> GRF[5]=0x1234. addu rd=0, alu_out=0xFFFF -> wb_en=0, read of $0 gives 0, instret still increments.
- Loads: dm_out=0x80FF7F01, each load to rt=8:
  - lb, off 3 -> 0xFFFFFF80; lbu, off 3 -> 0x00000080; lb, off 0 -> 0x00000001.
  - lh, off 2 -> 0xFFFF80FF; lhu, off 2 -> 0x000080FF; lw -> 0x80FF7F01.
- Bypass: GRF[9]=0x11; W writes 9 <- 0x22 with rs_addr_D=rt_addr_D=9 -> both read 0x22 the same cycle, array holds 0x22 next cycle. With BYPASS=0 the same cycle reads 0x11.
- Bubbles and no-write ops: w_flag=0 with ori rt=4 -> no write, no count, wb_addr=0, wb_data=0. Valid beq/sw/jr -> no write, instret +1 each.
- jalr and wrap: jalr rd=7, pc=0x3010 -> GRF[7]=0x3018. With INSTRET_W=4, 17 valid cycles -> instret=1.
